// File: rtl/if_prefetch_queue.sv
// Fetch stage: PC generation, credit-limited imem requests and a DEPTH-entry prefetch queue; head is combinational, freeze holds it.
// Issue stalls once count+inflight reaches DEPTH; flushes drop stale responses. Define IFQ_STATS_EN for the stat counters.
module if_prefetch_queue #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               freeze,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0]        stat_flushes,
    output logic [15:0]        stat_dropped,
    output logic [15:0]        stat_starve
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    CREDIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

    logic               run;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   req_rd;
    logic [PTR_W-1:0]   req_wr;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  req_mem   [DEPTH];
    logic [ADDR_W-1:0]  hold_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic               issue;
    logic               resp;
    logic               discard;
    logic               push;
    logic               pop;

    // run holds requests off until the first edge after reset release
    assign issue     = run && !branch_taken && (({1'b0, count} + {1'b0, inflight}) < CREDIT);
    assign resp      = imem_rvalid && (inflight != '0);
    assign discard   = resp && (branch_taken || (drop != '0));
    assign push      = resp && !discard;
    assign out_valid = (count != '0);
    assign pop       = out_valid && !freeze && !branch_taken;

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : hold_pc;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run        <= 1'b0;
            pc         <= '0;
            drop       <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            run <= 1'b1;
            if (branch_taken) begin
                pc   <= branch_addr;
                // a response landing in the flush cycle is already discarded
                drop <= inflight - CNT_W'(resp);
            end else begin
                if (issue)
                    pc <= pc + STEP;
                if (discard)
                    drop <= drop - CNT_W'(1);
            end
            if (out_valid) begin
                hold_pc    <= out_pc;
                hold_instr <= out_instr;
            end
        end
    end

    // prefetch data queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_mem[req_rd] + STEP;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    // request-address queue; survives flushes so responses still line up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_rd   <= '0;
            req_wr   <= '0;
            inflight <= '0;
        end else begin
            if (issue)
                req_wr <= req_wr + PTR_W'(1);
            if (resp)
                req_rd <= req_rd + PTR_W'(1);
            if (issue && !resp)
                inflight <= inflight + CNT_W'(1);
            else if (!issue && resp)
                inflight <= inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            req_mem[req_wr] <= pc;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == FULL));
    a_resp_expected: assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && inflight == '0));

`ifdef IFQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_flushes <= '0;
            stat_dropped <= '0;
            stat_starve  <= '0;
        end else begin
            if (branch_taken)
                stat_flushes <= sat_inc(stat_flushes);
            if (discard)
                stat_dropped <= sat_inc(stat_dropped);
            if (!out_valid)
                stat_starve <= sat_inc(stat_starve);
        end
    end
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        freeze = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IFQ_STATS_EN
    logic [15:0] stat_flushes;
    logic [15:0] stat_dropped;
    logic [15:0] stat_starve;
`endif

    always #5 clk = ~clk;

    if_prefetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .PC_STEP(4)) dut (
        .clk(clk),
        .rst(rst),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .freeze(freeze),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instr(out_instr)
`ifdef IFQ_STATS_EN
        ,
        .stat_flushes(stat_flushes),
        .stat_dropped(stat_dropped),
        .stat_starve(stat_starve)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;

    // memory: accepted requests with the cycle their response is presented
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t memq[$];

    // reference model: queue contents and outstanding requests tagged for drop
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; bit drop; } oreq_t;
    ent_t        m_fifo[$];
    oreq_t       m_out[$];
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;
    bit          m_run;
    int          m_flushes;
    int          m_dropped;
    int          m_starve;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_out.delete();
        m_pc = '0;
        m_last_pc = '0;
        m_last_instr = '0;
        m_run = 0;
        m_flushes = 0;
        m_dropped = 0;
        m_starve = 0;
    endtask

    task automatic step(input logic r, input logic bt, input logic [31:0] ba, input logic frz);
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        oreq_t       o;
        int          due;
        @(negedge clk);
        cyc++;
        rst = r;
        branch_taken = bt;
        branch_addr = ba;
        freeze = frz;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        if (!r) begin
            memq.delete();
            last_due = 0;
            model_reset();
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = instr_of(memq[0].addr);
            memq.delete(0);
        end
        #1;
        exp_req   = r && m_run && !bt && (m_fifo.size() + m_out.size() < DEPTH);
        exp_valid = (m_fifo.size() != 0);
        exp_pc    = exp_valid ? m_fifo[0].pc : m_last_pc;
        exp_instr = exp_valid ? m_fifo[0].instr : m_last_instr;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_pc", out_pc, exp_pc);
        chk("out_instr", out_instr, exp_instr);
`ifdef IFQ_STATS_EN
        chk("stat_flushes", 32'(stat_flushes), 32'(m_flushes));
        chk("stat_dropped", 32'(stat_dropped), 32'(m_dropped));
        chk("stat_starve", 32'(stat_starve), 32'(m_starve));
`endif
        if (r && imem_req) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            memq.push_back('{imem_addr, due});
            last_due = due;
        end
        if (r) begin
            if (!bt && exp_valid && !frz)
                m_fifo.delete(0);
            if (imem_rvalid && m_out.size() > 0) begin
                o = m_out[0];
                m_out.delete(0);
                if (bt || o.drop)
                    m_dropped++;
                else
                    m_fifo.push_back('{o.addr + 32'd4, imem_rdata});
            end
            if (bt) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].drop = 1'b1;
                m_pc = ba;
                m_flushes++;
            end else if (exp_req) begin
                m_out.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (exp_valid) begin
                m_last_pc = exp_pc;
                m_last_instr = exp_instr;
            end else begin
                m_starve++;
            end
            m_run = 1;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();

        // sequential fetch, 1-cycle memory
        lat = 1;
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_reset_valid", 32'(out_valid), 32'd0);
        chk("t1_reset_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_req0", 32'(imem_req), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t1_addr1", imem_addr, 32'h4);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_pc0", out_pc, 32'h4);
        chk("t1_instr0", out_instr, instr_of(32'h0));
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t1_pc1", out_pc, 32'h8);
        repeat (8) step(1'b1, 1'b0, '0, 1'b0);

        // freeze fills the queue, latency 2
        lat = 2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (i == 4) chk("t2_req_stop", 32'(imem_req), 32'd0);
        end
        chk("t2_req_full", 32'(imem_req), 32'd0);
        chk("t2_pc_hold", out_pc, 32'h4);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t2_pop0", out_pc, 32'h4);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t2_pop1", out_pc, 32'h8);
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t2_pop2", out_pc, 32'hC);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t2_pop3", out_pc, 32'h10);
        repeat (6) step(1'b1, 1'b0, '0, 1'b0);

        // flush with two requests in flight, latency 3
        lat = 3;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b0);
        chk("t3_flush_noreq", 32'(imem_req), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t3_redirect", imem_addr, 32'h100);
        chk("t3_redirect_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            chk("t3_dropped", 32'(out_valid), 32'd0);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t3_first_valid", 32'(out_valid), 32'd1);
        chk("t3_first_pc", out_pc, 32'h104);
        chk("t3_first_instr", out_instr, instr_of(32'h100));
        repeat (6) step(1'b1, 1'b0, '0, 1'b0);

        // flush coinciding with a response, inflight = 1
        lat = 1;
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t4_redirect", imem_addr, 32'h200);
        chk("t4_no_stale", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t4_no_stale2", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_pc", out_pc, 32'h204);
        chk("t4_instr", out_instr, instr_of(32'h200));
        repeat (4) step(1'b1, 1'b0, '0, 1'b0);

        // PC wrap at the top of the address space
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t5_wrap_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t5_wrap_pc", out_pc, 32'h0);
        chk("t5_wrap_instr", out_instr, instr_of(32'hFFFF_FFFC));
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t5_next_pc", out_pc, 32'h4);
        repeat (3) step(1'b1, 1'b0, '0, 1'b0);

        // asynchronous reset with a loaded queue and requests outstanding
        lat = 3;
        do_reset();
        repeat (5) step(1'b1, 1'b0, '0, 1'b1);
        chk("t6_loaded", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t6_req0", 32'(imem_req), 32'd0);
        chk("t6_addr0", imem_addr, 32'h0);
        chk("t6_valid0", 32'(out_valid), 32'd0);
        chk("t6_pc0", out_pc, 32'h0);
        chk("t6_instr0", out_instr, 32'h0);
        step(1'b0, 1'b0, '0, 1'b0);
        lat = 1;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t6_restart_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t6_restart_pc", out_pc, 32'h4);
        chk("t6_restart_instr", out_instr, instr_of(32'h0));
`ifdef IFQ_STATS_EN
        chk("t6_flushes_zero", 32'(stat_flushes), 32'd0);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t6_flushes_one", 32'(stat_flushes), 32'd1);
        step(1'b1, 1'b1, 32'h80, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t6_flushes_two", 32'(stat_flushes), 32'd2);
`endif
        repeat (5) step(1'b1, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
